// File: rtl/count_seq_pkg.sv
// Shared types and constants for the counter-sequence decoder.
package count_seq_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = 8;

   // Same encoding as the counter's mode_updown input
   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRST,
      S_TRACK,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/count_seq_step_calc.sv
// One arithmetic-progression step: prev +/- step, WIDTH+1 bits wide.
// The top bit is the carry (up) or borrow (down), i.e. the result left 0..2^WIDTH-1.
module count_seq_step_calc
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] step,
   input  logic             dir,
   output logic [WIDTH:0]   expected,
   output logic             out_of_range
);

   always_comb begin
      if (dir == DIR_DOWN) expected = {1'b0, prev} - {1'b0, step};
      else                 expected = {1'b0, prev} + {1'b0, step};
      out_of_range = expected[WIDTH];
   end

endmodule

// File: rtl/count_seq_decoder.sv
// Recovers init/step/direction from a sampled counter stream and checks later samples.
// Define COUNT_SEQ_DEC_CAPTURE_EN to add err_expected/err_got capture ports.
module count_seq_decoder
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample_val,
   input  logic [WIDTH-1:0] target,
   input  logic             flush,
   output logic             dec_valid,
   output logic [WIDTH-1:0] dec_init,
   output logic [WIDTH-1:0] dec_step,
   output logic             dec_dir,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             reached,
   output logic             seq_err,
   output logic [CNT_W-1:0] err_idx,
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
   output logic [WIDTH-1:0] err_expected,
   output logic [WIDTH-1:0] err_got,
`endif
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d, tgt_q, tgt_d, init_q, init_d, step_q, step_d;
   logic             dir_q, dir_d, dvalid_q, dvalid_d, reached_q, reached_d, err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d, cnt_inc;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
   logic [WIDTH-1:0] eexp_q, eexp_d, egot_q, egot_d;
`endif

   logic [WIDTH:0]   exp_val, diff;
   logic             exp_oor, diff_borrow;

   count_seq_step_calc #(.WIDTH(WIDTH)) u_track (
      .prev(prev_q), .step(step_q), .dir(dir_q),
      .expected(exp_val), .out_of_range(exp_oor)
   );

   // sample - prev; a borrow means the counter is going down
   count_seq_step_calc #(.WIDTH(WIDTH)) u_first (
      .prev(sample_val), .step(prev_q), .dir(DIR_DOWN),
      .expected(diff), .out_of_range(diff_borrow)
   );

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clkin) begin
      if (rst || flush) begin
         state_q   <= S_IDLE;
         prev_q    <= '0;
         tgt_q     <= '0;
         init_q    <= '0;
         step_q    <= '0;
         dir_q     <= 1'b0;
         dvalid_q  <= 1'b0;
         reached_q <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
         eexp_q    <= '0;
         egot_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         tgt_q     <= tgt_d;
         init_q    <= init_d;
         step_q    <= step_d;
         dir_q     <= dir_d;
         dvalid_q  <= dvalid_d;
         reached_q <= reached_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
         eexp_q    <= eexp_d;
         egot_q    <= egot_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      tgt_d     = tgt_q;
      init_d    = init_q;
      step_d    = step_q;
      dir_d     = dir_q;
      dvalid_d  = dvalid_q;
      reached_d = reached_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      eexp_d    = eexp_q;
      egot_d    = egot_q;
`endif
      if (sample_valid) begin
         unique case (state_q)
            S_IDLE: begin
               init_d = sample_val;
               prev_d = sample_val;
               tgt_d  = target;
               cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
               if (sample_val == target) begin
                  reached_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_FIRST;
               end
            end
            S_FIRST: begin
               cnt_d    = cnt_inc;
               dvalid_d = 1'b1;
               dir_d    = diff_borrow ? DIR_DOWN : DIR_UP;
               step_d   = diff_borrow ? WIDTH'(0) - diff[WIDTH-1:0] : diff[WIDTH-1:0];
               prev_d   = sample_val;
               if (sample_val == tgt_q) begin
                  reached_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_TRACK;
               end
            end
            S_TRACK: begin
               if (exp_oor || sample_val != exp_val[WIDTH-1:0]) begin
                  err_d   = 1'b1;
                  idx_d   = cnt_inc;
                  state_d = S_ERR;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
                  eexp_d  = exp_val[WIDTH-1:0];
                  egot_d  = sample_val;
`endif
               end else begin
                  prev_d = sample_val;
                  cnt_d  = cnt_inc;
                  if (sample_val == tgt_q) begin
                     reached_d = 1'b1;
                     state_d   = S_DONE;
                  end
               end
            end
            S_DONE, S_ERR: cnt_d = cnt_inc;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state_q == S_FIRST) || (state_q == S_TRACK);
      dec_valid  = dvalid_q;
      dec_init   = init_q;
      dec_step   = step_q;
      dec_dir    = dir_q;
      sample_cnt = cnt_q;
      reached    = reached_q;
      seq_err    = err_q;
      err_idx    = idx_q;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      err_expected = eexp_q;
      err_got      = egot_q;
`endif
   end

endmodule

// File: tb/tb_count_seq_decoder.sv
// Self-checking bench for count_seq_decoder against a per-sample behavioural model.
// Capture ports are checked when COUNT_SEQ_DEC_CAPTURE_EN is defined.
module tb_count_seq_decoder;

   localparam int W = 4;
   localparam int C = 8;
   localparam int VMAX = (1 << W) - 1;
   localparam int CMAX = (1 << C) - 1;

   logic         clkin = 1'b0;
   logic         rst = 1'b1, sample_valid = 1'b0, flush = 1'b0;
   logic [W-1:0] sample_val = '0, target = '0;
   logic         dec_valid, dec_dir, reached, seq_err, busy;
   logic [W-1:0] dec_init, dec_step;
   logic [C-1:0] sample_cnt, err_idx;
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
   logic [W-1:0] err_expected, err_got;
`endif

   count_seq_decoder #(.WIDTH(W), .CNT_W(C)) dut (
      .clkin(clkin), .rst(rst), .sample_valid(sample_valid), .sample_val(sample_val),
      .target(target), .flush(flush), .dec_valid(dec_valid), .dec_init(dec_init),
      .dec_step(dec_step), .dec_dir(dec_dir), .sample_cnt(sample_cnt), .reached(reached),
      .seq_err(seq_err), .err_idx(err_idx),
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      .err_expected(err_expected), .err_got(err_got),
`endif
      .busy(busy)
   );

   always #5 clkin = ~clkin;

   int total = 0;
   int bad = 0;

   // Model: phase 0 idle, 1 first seen, 2 tracking, 3 target hit, 4 error
   int m_phase, m_init, m_prev, m_tgt, m_step, m_dir, m_cnt, m_dval;
   int m_reached, m_err, m_idx, m_eexp, m_egot;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_init = 0; m_prev = 0; m_tgt = 0; m_step = 0; m_dir = 0;
      m_cnt = 0; m_dval = 0; m_reached = 0; m_err = 0; m_idx = 0; m_eexp = 0; m_egot = 0;
   endtask

   task automatic model_sample(input int s);
      int e;
      case (m_phase)
         0: begin
            m_init = s; m_prev = s; m_tgt = int'(target); m_cnt = 1;
            if (s == m_tgt) begin m_reached = 1; m_phase = 3; end
            else m_phase = 1;
         end
         1: begin
            m_cnt = sat(m_cnt + 1, CMAX); m_dval = 1;
            m_dir = (s < m_prev) ? 1 : 0;
            m_step = (s < m_prev) ? m_prev - s : s - m_prev;
            m_prev = s;
            if (s == m_tgt) begin m_reached = 1; m_phase = 3; end
            else m_phase = 2;
         end
         2: begin
            e = m_dir ? m_prev - m_step : m_prev + m_step;
            if (e < 0 || e > VMAX || s != e) begin
               m_err = 1; m_idx = sat(m_cnt + 1, CMAX); m_phase = 4;
               m_eexp = e & VMAX; m_egot = s;
            end else begin
               m_prev = s; m_cnt = sat(m_cnt + 1, CMAX);
               if (s == m_tgt) begin m_reached = 1; m_phase = 3; end
            end
         end
         default: m_cnt = sat(m_cnt + 1, CMAX);
      endcase
   endtask

   function automatic logic [63:0] exp_vec();
      logic [63:0] v;
      v = '0;
      v[28:0] = {1'(m_dval), 4'(m_init), 4'(m_step), 1'(m_dir), 8'(m_cnt),
                 1'(m_reached), 1'(m_err), 8'(m_idx), 1'(m_phase == 1 || m_phase == 2)};
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      v[36:29] = {4'(m_eexp), 4'(m_egot)};
`endif
      return v;
   endfunction

   function automatic logic [63:0] got_vec();
      logic [63:0] v;
      v = '0;
      v[28:0] = {dec_valid, dec_init, dec_step, dec_dir, sample_cnt, reached, seq_err, err_idx, busy};
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      v[36:29] = {err_expected, err_got};
`endif
      return v;
   endfunction

   // One clock: inputs change at negedge, outputs observed 1 time unit after posedge
   task automatic drive(input logic v, input int s, input logic r, input logic f);
      @(negedge clkin);
      sample_valid = v; sample_val = W'(s); rst = r; flush = f;
      @(posedge clkin);
      #1;
      if (r || f) model_reset();
      else if (v) model_sample(s);
   endtask

   task automatic test_reset();
      drive(1'b1, 7, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);
      total++;
      if (got_vec() !== 64'd0) begin
         bad++; $display("FAIL reset got=%h need=0", got_vec());
      end
      drive(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_up();
      int seq[5] = '{3, 5, 7, 9, 11};
      target = 4'd11;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, seq[i], 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL up s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if ({dec_init, dec_step, dec_dir, reached, sample_cnt, seq_err} !== {4'd3, 4'd2, 1'b0, 1'b1, 8'd5, 1'b0}) begin
         bad++; $display("FAIL up_final got=%h %h %b %b %0d %b", dec_init, dec_step, dec_dir, reached, sample_cnt, seq_err);
      end
   endtask

   task automatic test_down();
      int seq[4] = '{12, 9, 6, 3};
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd3;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, seq[i], 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL down s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if ({dec_dir, dec_step, reached, busy} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
         bad++; $display("FAIL down_final got dir=%b step=%0d reached=%b busy=%b", dec_dir, dec_step, reached, busy);
      end
   endtask

   task automatic test_deviation();
      int seq[4] = '{1, 4, 7, 9};
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd15;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, seq[i], 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL dev s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if ({seq_err, err_idx, reached, busy} !== {1'b1, 8'd4, 1'b0, 1'b0}) begin
         bad++; $display("FAIL dev_final got err=%b idx=%0d reached=%b busy=%b", seq_err, err_idx, reached, busy);
      end
`ifdef COUNT_SEQ_DEC_CAPTURE_EN
      total++;
      if ({err_expected, err_got} !== {4'd10, 4'd9}) begin
         bad++; $display("FAIL dev_capture got exp=%0d got=%0d need 10 9", err_expected, err_got);
      end
`endif
      drive(1'b1, 10, 1'b0, 1'b0);
      total++;
      if (got_vec() !== exp_vec()) begin
         bad++; $display("FAIL dev_hold got=%h need=%h", got_vec(), exp_vec());
      end
   endtask

   task automatic test_overflow();
      int seq[3] = '{10, 14, 2};
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, seq[i], 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL ovf s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if ({seq_err, err_idx, reached} !== {1'b1, 8'd3, 1'b0}) begin
         bad++; $display("FAIL ovf_final got err=%b idx=%0d reached=%b", seq_err, err_idx, reached);
      end
   endtask

   task automatic test_first_target();
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd5;
      drive(1'b1, 5, 1'b0, 1'b0);
      total++;
      if ({reached, dec_valid, sample_cnt, busy} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin
         bad++; $display("FAIL first_tgt got reached=%b dval=%b cnt=%0d busy=%b", reached, dec_valid, sample_cnt, busy);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom_range(0, VMAX), 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL first_tgt_more s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if (sample_cnt !== 8'd4) begin
         bad++; $display("FAIL first_tgt_cnt got=%0d need=4", sample_cnt);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd9;
      drive(1'b1, 0, 1'b0, 1'b0);
      drive(1'b1, 1, 1'b0, 1'b0);
      drive(1'b1, 2, 1'b1, 1'b0);
      total++;
      if (got_vec() !== 64'd0) begin
         bad++; $display("FAIL rst_mid got=%h need=0", got_vec());
      end
      target = 4'd2;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i, 1'b0, 1'b0);
         total++;
         if (got_vec() !== exp_vec()) begin
            bad++; $display("FAIL rst_mid_seq s%0d got=%h need=%h", i, got_vec(), exp_vec());
         end
      end
      total++;
      if ({dec_step, reached, dec_valid} !== {4'd1, 1'b1, 1'b1}) begin
         bad++; $display("FAIL rst_mid_final got step=%0d reached=%b dval=%b", dec_step, reached, dec_valid);
      end
   endtask

   task automatic test_saturate();
      drive(1'b0, 0, 1'b0, 1'b1);
      target = 4'd6;
      for (int i = 0; i < 257; i++) drive(1'b1, 5, 1'b0, 1'b0);
      drive(1'b1, 7, 1'b0, 1'b0);
      total++;
      if ({sample_cnt, err_idx, seq_err} !== {8'd255, 8'd255, 1'b1} || got_vec() !== exp_vec()) begin
         bad++; $display("FAIL sat_err got cnt=%0d idx=%0d err=%b", sample_cnt, err_idx, seq_err);
      end
      drive(1'b1, 7, 1'b0, 1'b0);
      total++;
      if (sample_cnt !== 8'd255) begin
         bad++; $display("FAIL sat_hold got cnt=%0d need=255", sample_cnt);
      end
   endtask

   task automatic test_random();
      int init, step, dir, len, v;
      for (int n = 0; n < 40; n++) begin
         drive(1'b0, 0, 1'b0, 1'b1);
         init = $urandom_range(0, VMAX);
         step = $urandom_range(0, 5);
         dir  = $urandom_range(0, 1);
         len  = $urandom_range(2, 8);
         target = ($urandom_range(0, 1) == 1) ? W'(init + (dir ? -1 : 1) * step * $urandom_range(1, len))
                                              : W'($urandom_range(0, VMAX));
         for (int k = 0; k < len; k++) begin
            v = (init + (dir ? -1 : 1) * step * k) & VMAX;
            if ($urandom_range(0, 9) == 0) v = v ^ (1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 3) == 0) begin
               drive(1'b0, $urandom_range(0, VMAX), 1'b0, 1'b0);
               total++;
               if (got_vec() !== exp_vec()) begin
                  bad++; $display("FAIL rnd_idle n%0d k%0d got=%h need=%h", n, k, got_vec(), exp_vec());
               end
            end
            drive(1'b1, v, 1'b0, ($urandom_range(0, 29) == 0));
            total++;
            if (got_vec() !== exp_vec()) begin
               bad++; $display("FAIL rnd n%0d k%0d got=%h need=%h", n, k, got_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_up();
      test_down();
      test_deviation();
      test_overflow();
      test_first_target();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
